// File: rtl/riscv_pkg.sv
// Shared RV32I encoding definitions: immediate formats, opcodes, field widths.
// No logic; types and constants only.
// Imported by the encoder, its packer and the bench.
package riscv_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int XLEN     = 32;
    localparam int OPCODE_W = 7;
    localparam int REG_W    = 5;
    localparam int FUNCT3_W = 3;

    // One pipeline stage payload: the encoded word plus its range flag.
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic            err;
    } enc_t;

endpackage

// File: rtl/imm_pack.sv
// Packs register/opcode fields and a 32-bit immediate into one RV32I word.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module imm_pack
    import riscv_pkg::*;
(
    input  logic [1:0]          imm_src,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [REG_W-1:0]    rd,
    input  logic [REG_W-1:0]    rs1,
    input  logic [REG_W-1:0]    rs2,
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic [XLEN-1:0]     imm,
    output logic [XLEN-1:0]     word,
    output logic                err
);

    // Sign-extension checks: the bits above the format's top bit must all
    // equal that top bit, otherwise the value does not fit.
    logic fits_12;
    logic fits_13;
    logic fits_21;

    assign fits_12 = (imm[31:11] == {21{imm[11]}});
    assign fits_13 = (imm[31:12] == {20{imm[12]}});
    assign fits_21 = (imm[31:20] == {12{imm[20]}});

    // Field placement per format; branch/jump offsets must also be even.
    always_comb begin
        word = '0;
        err  = 1'b0;
        case (imm_src_t'(imm_src))
            IMM_I: begin
                word = {imm[11:0], rs1, funct3, rd, opcode};
                err  = !fits_12;
            end
            IMM_S: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err  = !fits_12;
            end
            IMM_B: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err  = !fits_13 || imm[0];
            end
            IMM_J: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err  = !fits_21 || imm[0];
            end
            default: begin
                word = '0;
                err  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Encodes instruction fields + immediate into RV32I words tagged with imem byte addresses.
// Latency: 2 cycles from input handshake to out_valid; one word per cycle sustained.
// Backpressure: out_ready stalls S2, then S1; in_ready drops only when both stages are held.
// Optional IMM_ERR_CNT_EN adds err_cnt, a saturating count of emitted words flagged imm_err.
module inst_encoder
    import riscv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          imm_src,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [REG_W-1:0]    rd,
    input  logic [REG_W-1:0]    rs1,
    input  logic [REG_W-1:0]    rs2,
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic [XLEN-1:0]     imm,
    input  logic                clear,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     inst_out,
    output logic [XLEN-1:0]     out_addr,
    output logic                imm_err
`ifdef IMM_ERR_CNT_EN
    ,
    output logic [7:0]          err_cnt
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    enc_t             pack_dat;
    enc_t             s1_dat;
    enc_t             s2_dat;
    logic             s1_vld;
    logic             s2_vld;
    logic             s1_adv;
    logic             s2_adv;
    logic             out_hs;
    logic [IDX_W-1:0] word_idx;

    imm_pack u_imm_pack (
        .imm_src (imm_src),
        .opcode  (opcode),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .funct3  (funct3),
        .imm     (imm),
        .word    (pack_dat.inst),
        .err     (pack_dat.err)
    );

    assign s2_adv   = !s2_vld || out_ready;
    assign s1_adv   = !s1_vld || s2_adv;
    assign in_ready = s1_adv;
    assign out_hs   = s2_vld && out_ready;

    assign out_valid = s2_vld;
    assign inst_out  = s2_dat.inst;
    assign imm_err   = s2_dat.err;

    // The address is derived from a word index so the DEPTH wrap falls out of
    // the counter width; DEPTH is a power of two.
    assign out_addr = BASE_ADDR + {{(XLEN-IDX_W-2){1'b0}}, word_idx, 2'b00};

    // S1: capture the packed word whenever the stage is free to move.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else if (s1_adv) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_dat <= pack_dat;
            end
        end
    end

    // S2: output register; payload holds while out_valid && !out_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_vld <= 1'b0;
            s2_dat <= '0;
        end else if (s2_adv) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_dat <= s1_dat;
            end
        end
    end

    // Address index: steps on each output handshake; clear overrides it.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word_idx <= '0;
        end else if (out_hs) begin
            word_idx <= word_idx + 1'b1;
        end
    end

`ifdef IMM_ERR_CNT_EN
    // Saturating count of emitted words carrying imm_err; clear zeroes it.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            err_cnt <= '0;
        end else if (out_hs && s2_dat.err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: packing, range flags, latency, backpressure,
// address wrap with DEPTH=4, clear and mid-flight reset.
module tb_inst_encoder;
    import riscv_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  imm_src;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst_out;
    logic [31:0] out_addr;
    logic        imm_err;
`ifdef IMM_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int total = 0;
    int bad   = 0;

    inst_encoder #(
        .BASE_ADDR (BASE),
        .DEPTH     (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_src   (imm_src),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .imm       (imm),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst_out  (inst_out),
        .out_addr  (out_addr),
        .imm_err   (imm_err)
`ifdef IMM_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] src, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [31:0] im);
        imm_src  = src;
        opcode   = op;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        funct3   = f3;
        imm      = im;
        in_valid = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clear     = 1'b0;
        imm_src   = 2'b00;
        opcode    = '0;
        rd        = '0;
        rs1       = '0;
        rs2       = '0;
        funct3    = '0;
        imm       = '0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_inst_out", inst_out, 32'd0);
        chk("rst_out_addr", out_addr, BASE);
        chk("rst_imm_err", {31'd0, imm_err}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // I-type, then check the two-cycle latency
        drive(IMM_I, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFFF_FFFF);
        step();
        in_valid = 1'b0;
        chk("lat_one_cycle", {31'd0, out_valid}, 32'd0);
        step();
        chk("i_valid", {31'd0, out_valid}, 32'd1);
        chk("i_inst", inst_out, 32'hFFF1_0093);
        chk("i_err", {31'd0, imm_err}, 32'd0);
        chk("i_addr", out_addr, BASE);
        step();

        // S, B, J back to back
        drive(IMM_S, OP_STORE, 5'd0, 5'd2, 5'd5, 3'b010, 32'd8);
        step();
        drive(IMM_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC);
        step();
        chk("s_inst", inst_out, 32'h0051_2423);
        chk("s_addr", out_addr, BASE + 32'd4);
        drive(IMM_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        step();
        in_valid = 1'b0;
        chk("b_inst", inst_out, 32'hFE00_0EE3);
        chk("b_addr", out_addr, BASE + 32'd8);
        step();
        chk("j_inst", inst_out, 32'h0010_00EF);
        chk("j_addr", out_addr, BASE + 32'd12);
        step();
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("wrap_addr", out_addr, BASE);

        // Range errors
        drive(IMM_I, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 32'd2048);
        step();
        drive(IMM_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3);
        step();
        chk("ierr_inst", inst_out, 32'h8001_0093);
        chk("ierr_err", {31'd0, imm_err}, 32'd1);
        chk("ierr_addr", out_addr, BASE);
        drive(IMM_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFF0_0000);
        step();
        in_valid = 1'b0;
        chk("berr_inst", inst_out, 32'h0000_0163);
        chk("berr_err", {31'd0, imm_err}, 32'd1);
        step();
        chk("jmin_inst", inst_out, 32'h8000_00EF);
        chk("jmin_err", {31'd0, imm_err}, 32'd0);
        chk("jmin_addr", out_addr, BASE + 32'd8);
`ifdef IMM_ERR_CNT_EN
        chk("err_cnt", {24'd0, err_cnt}, 32'd2);
`endif
        step();

        // Backpressure: three words against a stalled output
        out_ready = 1'b0;
        drive(IMM_I, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 32'd1);
        chk("bp_rdy0", {31'd0, in_ready}, 32'd1);
        step();
        drive(IMM_I, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 32'd2);
        chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
        step();
        drive(IMM_I, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 32'd3);
        chk("bp_full_rdy", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_inst", inst_out, 32'h0011_0093);
        step();
        step();
        step();
        chk("bp_still_rdy", {31'd0, in_ready}, 32'd0);
        chk("bp_still_inst", inst_out, 32'h0011_0093);
        chk("bp_still_addr", out_addr, BASE + 32'd12);
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_w1_inst", inst_out, 32'h0021_0093);
        chk("bp_w1_addr", out_addr, BASE);
        step();
        chk("bp_w2_inst", inst_out, 32'h0031_0093);
        chk("bp_w2_addr", out_addr, BASE + 32'd4);
        step();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // clear with a concurrent output handshake
        drive(IMM_I, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 32'd4);
        step();
        in_valid = 1'b0;
        step();
        chk("clr_inst", inst_out, 32'h0041_0093);
        chk("clr_old_addr", out_addr, BASE + 32'd8);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_addr", out_addr, BASE);
        chk("clr_valid", {31'd0, out_valid}, 32'd0);
`ifdef IMM_ERR_CNT_EN
        chk("clr_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif

        // Reset with two words in flight
        out_ready = 1'b0;
        drive(IMM_I, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 32'd5);
        step();
        drive(IMM_I, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 32'd6);
        step();
        in_valid = 1'b0;
        chk("inflight_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_inst", inst_out, 32'd0);
        step();
        chk("mid_rst_s1_dropped", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_addr", out_addr, BASE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
